// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - receive-side checker for the x^4+x^3+1 LFSR stream
// Seeds a local predictor, locks after a clean run, flywheels through errors and counts them.
module lfsr_checker #(
  parameter int LOCK_CNT  = 4,
  parameter int LOSS_CNT  = 3,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           data_in,
  input  logic                 data_valid,
  input  logic                 clear_err,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t               state, state_d;
  logic [3:0]           pred, pred_d;
  logic [MATCH_W-1:0]   match_cnt, match_d;
  logic [MISS_W-1:0]    miss_cnt, miss_d;
  logic                 pulse_d;
  logic                 err_inc;
  logic [ERR_CNT_W-1:0] err_count_d;

  function automatic logic [3:0] lfsr_next(input logic [3:0] v);
    return {v[2:0], v[3] ^ v[2]};
  endfunction

  always_comb begin
    state_d = state;
    pred_d  = pred;
    match_d = match_cnt;
    miss_d  = miss_cnt;
    pulse_d = 1'b0;
    err_inc = 1'b0;
    if (data_valid) begin
      case (state)
        SEARCH: begin
          if (data_in != 4'd0) begin
            pred_d  = lfsr_next(data_in);
            match_d = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (data_in == pred) begin
            pred_d = lfsr_next(data_in);
            if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end else begin
              match_d = match_cnt + 1'b1;
            end
          end else if (data_in != 4'd0) begin
            pred_d  = lfsr_next(data_in);
            match_d = '0;
          end else begin
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          // Flywheel: the predictor advances on its own, never from data_in.
          pred_d = lfsr_next(pred);
          if (data_in == pred) begin
            miss_d = '0;
          end else begin
            pulse_d = 1'b1;
            err_inc = 1'b1;
            miss_d  = miss_cnt + 1'b1;
            if (miss_cnt == MISS_W'(LOSS_CNT - 1)) begin
              state_d = SEARCH;
              miss_d  = '0;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    err_count_d = err_count;
    if (clear_err) begin
      err_count_d = '0;
    end else if (err_inc && !(&err_count)) begin
      err_count_d = err_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SEARCH;
      pred      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_d;
      pred      <= pred_d;
      match_cnt <= match_d;
      miss_cnt  <= miss_d;
      locked    <= (state_d == LOCKED);
      err_pulse <= pulse_d;
      err_count <= err_count_d;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - randomized self-checking bench for lfsr_checker
// Two instances share stimulus: default widths and a 2-bit error counter for saturation.
module tb_lfsr_checker;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] data_in;
  logic       data_valid;
  logic       clear_err;
  logic        locked_a, pulse_a;
  logic [15:0] cnt_a;
  logic        locked_b, pulse_b;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_CNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
    .clear_err(clear_err), .locked(locked_a), .err_pulse(pulse_a), .err_count(cnt_a)
  );

  lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
    .clear_err(clear_err), .locked(locked_b), .err_pulse(pulse_b), .err_count(cnt_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                           4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  // Reference: mode 0=search 1=verify 2=locked; m_idx is the position of the expected value in seq.
  int m_mode, m_idx, m_match, m_miss, m_err16, m_err2;
  bit m_pulse;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pos(input logic [3:0] v);
    for (int i = 0; i < 15; i++) if (seq[i] == v) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_match = 0; m_miss = 0;
    m_err16 = 0; m_err2 = 0; m_pulse = 0;
  endtask

  task automatic model_update(input logic [3:0] v, input bit valid, input bit clr);
    bit hit;
    m_pulse = 0;
    if (valid) begin
      case (m_mode)
        0: if (v != 0) begin
             m_idx = (pos(v) + 1) % 15; m_match = 0; m_mode = 1;
           end
        1: begin
             if (v == seq[m_idx]) begin
               m_idx = (m_idx + 1) % 15;
               if (m_match == LOCK_CNT - 1) begin m_mode = 2; m_miss = 0; end
               else m_match++;
             end else if (v != 0) begin
               m_idx = (pos(v) + 1) % 15; m_match = 0;
             end else begin
               m_mode = 0;
             end
           end
        default: begin
             hit = (v == seq[m_idx]);
             m_idx = (m_idx + 1) % 15;
             if (hit) m_miss = 0;
             else begin
               m_pulse = 1;
               if (m_err16 < 65535) m_err16++;
               if (m_err2 < 3) m_err2++;
               m_miss++;
               if (m_miss == LOSS_CNT) begin m_mode = 0; m_miss = 0; end
             end
           end
      endcase
    end
    if (clr) begin m_err16 = 0; m_err2 = 0; end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".locked_a"}, locked_a, (m_mode == 2));
    check({tag, ".pulse_a"},  pulse_a,  m_pulse);
    check({tag, ".count_a"},  cnt_a,    m_err16);
    check({tag, ".locked_b"}, locked_b, (m_mode == 2));
    check({tag, ".pulse_b"},  pulse_b,  m_pulse);
    check({tag, ".count_b"},  cnt_b,    m_err2);
  endtask

  task automatic step(input string tag, input logic [3:0] v, input bit valid, input bit clr);
    @(negedge clk);
    data_in = v; data_valid = valid; clear_err = clr;
    @(posedge clk);
    model_update(v, valid, clr);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; data_valid = 1'b0; clear_err = 1'b0; data_in = 4'h0;
    #1;
    model_reset();
    compare_all("reset");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic acquire(input string tag, input int start);
    for (int i = 0; i < 5; i++) step(tag, seq[(start + i) % 15], 1'b1, 1'b0);
  endtask

  logic [3:0] exp_v;

  initial begin
    reset_n = 1'b1; data_in = 4'h0; data_valid = 1'b0; clear_err = 1'b0;
    model_reset();
    do_reset();

    // Acquire: lock rises at the fifth beat
    for (int i = 0; i < 4; i++) step("acq", seq[i], 1'b1, 1'b0);
    check("acq_pre_lock", locked_a, 1'b0);
    step("acq", seq[4], 1'b1, 1'b0);
    check("acq_lock", locked_a, 1'b1);

    // Single error then flywheel alignment
    step("single", 4'h7, 1'b1, 1'b0);
    check("single_pulse", pulse_a, 1'b1);
    step("single", 4'hD, 1'b1, 1'b0);
    step("single", 4'hA, 1'b1, 1'b0);
    check("single_count", cnt_a, 16'd1);
    check("single_locked", locked_a, 1'b1);

    // Loss of lock then relock
    for (int i = 0; i < 3; i++) step("loss", 4'h0, 1'b1, 1'b0);
    check("loss_locked", locked_a, 1'b0);
    check("loss_count", cnt_a, 16'd4);
    acquire("relock", 0);
    check("relock", locked_a, 1'b1);

    // Zeros in search, then acquire through gaps
    do_reset();
    step("zeros", 4'h0, 1'b1, 1'b0);
    step("zeros", 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      int gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) step("gap_idle", 4'($urandom), 1'b0, 1'b0);
      step("gap", seq[i], 1'b1, 1'b0);
    end
    check("gap_lock", locked_a, 1'b1);

    // Saturation of the 2-bit counter, then clear against an error
    for (int e = 0; e < 5; e++) begin
      exp_v = seq[m_idx] ^ 4'h1;
      step("sat_err", exp_v, 1'b1, 1'b0);
      check("sat_count_b", cnt_b, (e < 3) ? e + 1 : 3);
      step("sat_ok", seq[m_idx], 1'b1, 1'b0);
    end
    exp_v = seq[m_idx] ^ 4'h2;
    step("clr_err", exp_v, 1'b1, 1'b1);
    check("clr_count", cnt_a, 16'd0);
    check("clr_pulse", pulse_a, 1'b1);

    // Async reset mid-lock with two errors counted
    step("pre_async", seq[m_idx] ^ 4'h4, 1'b1, 1'b0);
    step("pre_async", seq[m_idx], 1'b1, 1'b0);
    step("pre_async", seq[m_idx] ^ 4'h4, 1'b1, 1'b0);
    check("pre_async_count", cnt_a, 16'd2);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_locked", locked_a, 1'b0);
    check("async_count", cnt_a, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    acquire("reacq", 14);
    check("reacq_lock", locked_a, 1'b1);

    // Randomized traffic against the reference
    for (int n = 0; n < 3000; n++) begin
      int r = $urandom_range(0, 99);
      bit clr = ($urandom_range(0, 49) == 0);
      if (r < 60)      exp_v = (m_mode == 0) ? seq[$urandom_range(0, 14)] : seq[m_idx];
      else if (r < 75) exp_v = 4'($urandom);
      else             exp_v = 4'h0;
      step("rand", exp_v, (r < 90), clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side checker for the 4-bit LFSR sequence generator; consumes its `shift_value` stream one beat per `data_valid`.
- Self-synchronises a local predictor to the incoming stream and declares lock.
- Flywheels through isolated errors, counts mismatches, and drops lock after a run of consecutive misses.
- Sits directly downstream of the LFSR as the pass/fail monitor for the pattern path.

Parameters:
LOCK_CNT, 4, consecutive correct predictions required, after seeding, to enter LOCKED (>=1)
LOSS_CNT, 3, consecutive mismatches in LOCKED that force return to SEARCH (>=1)
ERR_CNT_W, 16, width of the saturating error counter

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
data_in  input  4  received LFSR value
data_valid  input  1  data_in is sampled on this clk edge
clear_err  input  1  synchronous clear of err_count
locked  output  1  high while in LOCKED
err_pulse  output  1  one-cycle pulse per mismatch counted in LOCKED
err_count  output  ERR_CNT_W  saturating mismatch count

Behaviour:
- Sequence polynomial x^4+x^3+1, Fibonacci, left shift: next(v) = {v[2:0], v[3]^v[2]}.
- Period is 15; all-zero is illegal.
- Sequence from 1 (hex): 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8,1…
- Reset (reset_n low, async):
  - state=SEARCH; pred, match_cnt and miss_cnt = 0.
  - locked=0, err_pulse=0, err_count=0.
  - Applies immediately, mid-operation included; release is synchronous to the next edge.
- All outputs are registered.
- Cycles with data_valid=0:
  - Hold all state.
  - err_pulse=0.
- SEARCH (on valid beat):
  - data_in != 0 -> pred=next(data_in), match_cnt=0, go VERIFY.
  - data_in == 0 -> stay in SEARCH.
- VERIFY (on valid beat):
  - data_in == pred, match_cnt==LOCK_CNT-1 -> go LOCKED; locked=1 from that edge.
  - data_in == pred otherwise -> match_cnt+1, pred=next(data_in).
  - Mismatch, data_in nonzero -> reseed: pred=next(data_in), match_cnt=0, stay in VERIFY.
  - Mismatch, data_in zero -> go SEARCH.
  - No errors are counted in VERIFY.
- LOCKED (on valid beat):
  - pred=next(pred) always (flywheel; never reseeded from data_in).
  - Match -> miss_cnt=0.
  - Mismatch:
    - err_pulse=1 for exactly one cycle after the sampling edge.
    - err_count+1, saturating at all-ones.
    - miss_cnt+1.
  - Mismatch with miss_cnt==LOSS_CNT-1 -> go SEARCH, locked=0 at the same edge. That error is still counted and pulsed.
- Zero data_in in LOCKED is an ordinary mismatch.
- clear_err:
  - Sets err_count=0 at the edge and wins over a simultaneous increment.
  - err_pulse still fires for that beat.
  - Does not affect lock state.
- Lock latency: locked rises at the edge sampling beat LOCK_CNT+1 of an error-free run (seed + LOCK_CNT matches).

Test Plan:
- Acquire:
  - Stimulus: reset_n released; valid every cycle with 1,2,4,9,3 (LOCK_CNT=4).
  - Required: locked=0 through beat 4, locked=1 after the edge sampling 3; err_count=0, no err_pulse.
- Single error:
  - Stimulus: locked; next expected 6, send 7, then D,A.
  - Required: one err_pulse, err_count=1, locked stays 1; D and A produce no pulse (flywheel held alignment).
- Loss of lock:
  - Stimulus: locked; send 0,0,0 (LOSS_CNT=3).
  - Required: three err_pulses, err_count+3, locked=0 after the third edge.
  - Follow-up: resend 1,2,4,9,3 -> relocks.
- Gaps and zeros:
  - Stimulus 1: in SEARCH, send 0,0 -> stays in SEARCH.
  - Stimulus 2: send 1,2,4,9,3 with data_valid low 1–3 cycles between beats.
  - Required: identical lock timing in valid beats; no pulses.
- Saturation and clear:
  - Stimulus: ERR_CNT_W=2, locked; alternate error/correct for 5 errors.
  - Required: err_count 1,2,3,3,3.
  - Stimulus: assert clear_err on the same edge as a further error.
  - Required: err_count=0, err_pulse=1.
- Async reset mid-lock:
  - Stimulus: pulse reset_n low between clock edges while locked with err_count=2.
  - Required: locked=0, err_count=0 immediately, without a clock edge.
  - Follow-up: after release, reacquire with 8,1,2,4,9 -> locked.
